// File: rtl/aes_keysched_ark.sv
// AES key expansion (one schedule word per cycle) with registered word readback
// and AddRoundKey of a latched 128-bit block for any selected round.
module aes_keysched_ark #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*NK-1:0]  key_in,
    input  logic [127:0]      data_in,
    input  logic [3:0]        round_sel,
    input  logic [5:0]        kaddr,
    output logic              busy,
    output logic              done,
    output logic              key_valid,
    output logic [31:0]       kword,
    output logic [127:0]      state_out
);

    localparam int NB = 4;
    localparam int NR = NK + 6;
    localparam int NW = NB * (NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_keysched_ark: NK must be 4, 6 or 8");
    end

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_FLAT[2047 - 8*int'(b) -: 8];
    endfunction

    // Companion tables for the downstream datapath, derived from the S-box and
    // from repeated multiplication by the generator 03 in GF(2^8).
    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
        logic [7:0] res;
        res = 8'h00;
        for (int j = 0; j < 256; j++) begin
            if (sbox_byte(8'(j)) == b) res = 8'(j);
        end
        return res;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] exp3_byte(input logic [7:0] e);
        logic [7:0] x;
        x = 8'h01;
        for (int k = 0; k < 256; k++) begin
            if (k < int'(e)) x = x ^ xtime(x);
        end
        return x;
    endfunction

    function automatic logic [7:0] ln3_byte(input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] res;
        x   = 8'h01;
        res = 8'h00;
        for (int k = 0; k < 255; k++) begin
            if (x == b) res = 8'(k);
            x = x ^ xtime(x);
        end
        return res;
    endfunction

    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h8d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          idx_q, idx_d;
    logic [2:0]          mod_q, mod_d;
    logic [3:0]          rcon_q, rcon_d;
    logic [32*NK-1:0]    key_q, key_d;
    logic [127:0]        data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                key_valid_q, key_valid_d;
    logic [31:0]         kword_q, kword_d;
    logic [127:0]        state_out_q, state_out_d;

    logic [31:0]         key_mem [0:63];
    logic [31:0]         prev_word;
    logic [31:0]         back_word;
    logic [31:0]         temp_word;
    logic [31:0]         new_word;

    // Recurrence inputs: w[i-1] and w[i-NK] come straight from the schedule
    // memory, since w[i-1] was committed on the previous edge.
    always_comb begin
        prev_word = key_mem[idx_q - 6'd1];
        back_word = key_mem[idx_q - 6'(NK)];
        if (mod_q == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]})
                        ^ {rcon_byte(rcon_q), 24'h000000};
        end else if (NK > 6 && mod_q == 3'd4) begin
            temp_word = sub_word(prev_word);
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mod_d       = mod_q;
        rcon_d      = rcon_q;
        key_d       = key_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d       = key_in;
                    data_d      = data_in;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                idx_d   = 6'(NK);
                mod_d   = 3'd0;
                rcon_d  = 4'd1;
                state_d = EXPAND;
            end
            EXPAND: begin
                idx_d  = idx_q + 6'd1;
                mod_d  = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
                rcon_d = (mod_q == 3'd0) ? rcon_q + 4'd1 : rcon_q;
                if (int'(idx_q) == NW - 1) begin
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Readback paths: both outputs see only a completed schedule.
    always_comb begin
        kword_d = 32'h0;
        if (key_valid_q && int'(kaddr) < NW) begin
            kword_d = key_mem[kaddr];
        end

        state_out_d = data_q;
        if (key_valid_q && int'(round_sel) <= NR) begin
            for (int c = 0; c < 4; c++) begin
                state_out_d[127 - 32*c -: 32] = data_q[127 - 32*c -: 32]
                    ^ key_mem[{round_sel, 2'(c)}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 6'd0;
            mod_q       <= 3'd0;
            rcon_q      <= 4'd0;
            key_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            kword_q     <= 32'h0;
            state_out_q <= 128'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mod_q       <= mod_d;
            rcon_q      <= rcon_d;
            key_q       <= key_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            kword_q     <= kword_d;
            state_out_q <= state_out_d;
        end
    end

    // Schedule memory carries no reset; its contents only matter once key_valid is set.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            for (int k = 0; k < NK; k++) begin
                key_mem[k] <= key_q[32*NK - 1 - 32*k -: 32];
            end
        end else if (state_q == EXPAND) begin
            key_mem[idx_q] <= new_word;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign kword     = kword_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_aes_keysched_ark.sv
// Directed bench for aes_keysched_ark: AES-128 and AES-256 instances checked
// against FIPS-197 schedule words, AddRoundKey results and control timing.
module tb_aes_keysched_ark;

   logic          clock = 1'b0;
   logic          rst;
   logic          start4;
   logic          start8;
   logic [127:0]  key4;
   logic [255:0]  key8;
   logic [127:0]  dataIn;
   logic [3:0]    roundSel;
   logic [5:0]    kaddr;

   logic          busy4, done4, keyValid4;
   logic [31:0]   kword4;
   logic [127:0]  stateOut4;
   logic          busy8, done8, keyValid8;
   logic [31:0]   kword8;
   logic [127:0]  stateOut8;

   int compareCount  = 0;
   int mismatchCount = 0;

   localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] KEY256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] PLAIN  = 128'h3243f6a8885a308d313198a2e0370734;

   always #5 clock = ~clock;

   aes_keysched_ark #(.NK(4)) dut4 (
      .clk(clock), .rst(rst), .start(start4), .key_in(key4), .data_in(dataIn),
      .round_sel(roundSel), .kaddr(kaddr), .busy(busy4), .done(done4),
      .key_valid(keyValid4), .kword(kword4), .state_out(stateOut4)
   );

   aes_keysched_ark #(.NK(8)) dut8 (
      .clk(clock), .rst(rst), .start(start8), .key_in(key8), .data_in(dataIn),
      .round_sel(roundSel), .kaddr(kaddr), .busy(busy8), .done(done8),
      .key_valid(keyValid8), .kword(kword8), .state_out(stateOut8)
   );

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just past the rising edge.
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Pulse start for one edge on the chosen instance with the given key and block.
   task automatic applyStimulus(input logic use8, input logic [255:0] key,
                                input logic [127:0] data);
      dataIn = data;
      if (use8) begin
         key8   = key;
         start8 = 1'b1;
      end else begin
         key4   = key[127:0];
         start4 = 1'b1;
      end
      stepCycle();
      start4 = 1'b0;
      start8 = 1'b0;
   endtask

   // Count edges until done shows up; a timeout leaves cycles at zero.
   task automatic waitDone(input logic use8, output int cycles);
      cycles = 0;
      for (int n = 1; n <= 100; n++) begin
         stepCycle();
         if ((use8 ? done8 : done4) === 1'b1) begin
            cycles = n;
            break;
         end
      end
   endtask

   task automatic readWord(input logic use8, input logic [5:0] addr,
                           output logic [31:0] value);
      kaddr = addr;
      stepCycle();
      value = use8 ? kword8 : kword4;
   endtask

   initial begin
      int          cycles;
      int          donePulses;
      logic [31:0] word;
      logic [5:0]  addrs4 [9];
      logic [31:0] words4 [9];

      addrs4 = '{6'd0, 6'd4, 6'd5, 6'd6, 6'd7, 6'd40, 6'd41, 6'd42, 6'd43};
      words4 = '{32'h2b7e1516, 32'ha0fafe17, 32'h88542cb1, 32'h23a33939,
                 32'h2a6c7605, 32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8,
                 32'hb6630ca6};

      rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
      key4 = '0; key8 = '0; dataIn = '0; roundSel = 4'd0; kaddr = 6'd0;
      repeat (3) stepCycle();
      rst = 1'b0;
      checkOutput("reset busy",      {127'b0, busy4},     128'd0);
      checkOutput("reset done",      {127'b0, done4},     128'd0);
      checkOutput("reset key_valid", {127'b0, keyValid4}, 128'd0);
      checkOutput("reset kword",     {96'b0, kword4},     128'd0);
      checkOutput("reset state_out", stateOut4,           128'd0);

      // AES-128 expansion with the FIPS plaintext block latched.
      applyStimulus(1'b0, {128'b0, KEY128}, PLAIN);
      checkOutput("busy after start", {127'b0, busy4}, 128'd1);
      waitDone(1'b0, cycles);
      checkOutput("nk4 done latency", 128'(cycles), 128'd41);
      checkOutput("nk4 key_valid at done", {127'b0, keyValid4}, 128'd1);
      checkOutput("nk4 busy at done", {127'b0, busy4}, 128'd0);
      stepCycle();
      checkOutput("nk4 done is a pulse", {127'b0, done4}, 128'd0);

      for (int i = 0; i < 9; i++) begin
         readWord(1'b0, addrs4[i], word);
         checkOutput($sformatf("nk4 w[%0d]", addrs4[i]), {96'b0, word}, {96'b0, words4[i]});
      end

      roundSel = 4'd0;
      stepCycle();
      checkOutput("nk4 ark round0", stateOut4, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      roundSel = 4'd11;
      stepCycle();
      checkOutput("nk4 ark round11 passthrough", stateOut4, PLAIN);

      // Re-expansion with a zero block; a second start mid-run must be ignored.
      applyStimulus(1'b0, {128'b0, KEY128}, 128'd0);
      checkOutput("restart clears key_valid", {127'b0, keyValid4}, 128'd0);
      repeat (8) stepCycle();
      start4 = 1'b1;
      stepCycle();
      start4 = 1'b0;
      waitDone(1'b0, cycles);
      checkOutput("nk4 done latency with stray start", 128'(cycles + 9), 128'd41);
      roundSel = 4'd10;
      stepCycle();
      checkOutput("nk4 ark round10", stateOut4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Reset twenty cycles into an expansion must abort with no done pulse.
      applyStimulus(1'b0, {128'b0, KEY128}, PLAIN);
      repeat (20) stepCycle();
      rst   = 1'b1;
      kaddr = 6'd4;
      stepCycle();
      rst = 1'b0;
      checkOutput("abort busy",      {127'b0, busy4},     128'd0);
      checkOutput("abort key_valid", {127'b0, keyValid4}, 128'd0);
      checkOutput("abort kword",     {96'b0, kword4},     128'd0);
      donePulses = 0;
      for (int n = 0; n < 40; n++) begin
         stepCycle();
         if (done4 === 1'b1) donePulses++;
      end
      checkOutput("abort no done pulse", 128'(donePulses), 128'd0);
      checkOutput("abort kword stays zero", {96'b0, kword4}, 128'd0);

      // AES-256 expansion.
      applyStimulus(1'b1, KEY256, 128'd0);
      waitDone(1'b1, cycles);
      checkOutput("nk8 done latency", 128'(cycles), 128'd53);
      readWord(1'b1, 6'd0, word);
      checkOutput("nk8 w[0]", {96'b0, word}, {96'b0, 32'h603deb10});
      readWord(1'b1, 6'd8, word);
      checkOutput("nk8 w[8]", {96'b0, word}, {96'b0, 32'h9ba35411});
      readWord(1'b1, 6'd59, word);
      checkOutput("nk8 w[59]", {96'b0, word}, {96'b0, 32'h706c631e});
      readWord(1'b1, 6'd60, word);
      checkOutput("nk8 w[60] out of range", {96'b0, word}, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
